avalon_cmd_master: RTL

Byte-stream-to-Avalon-MM write master that sits directly upstream of the exam system's `s0` slave port. It sits between the byte receiver (UART RX or test source) and the exam system. It parses framed commands from an 8-bit valid/ready stream and verifies an XOR checksum. Each good frame becomes one Avalon-MM write (`address`, `write`, `writedata`, `waitrequest`), which drives the register behind the `R` export.

---
 rtl/avalon_cmd_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/avalon_cmd_master.sv
// avalon_cmd_master: parses framed byte commands (SYNC, ADDR, D0..D3, CSUM)
// from a valid/ready byte stream, checks the XOR checksum and issues one
// Avalon-MM write per good frame.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   in_data/valid/ready    - 8-bit input byte stream
//   address/write/writedata/waitrequest - Avalon-MM write master
//   frame_cnt/err_cnt      - saturating good-write / error counters
//   busy                   - high whenever a frame is in progress
module avalon_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  address,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_WRITE
    } state_t;

    localparam int unsigned TW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LIM =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    address_q, address_d;
    logic [31:0]   writedata_q, writedata_d;
    logic          write_q, write_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   err_q, err_d;
    // Keeps in_ready low until the first edge after reset release.
    logic          en_q;

    logic accept;
    logic timed;
    logic tmo;
    logic csum_ok;

    assign accept  = in_valid & in_ready;
    assign timed   = (state_q == S_ADDR) || (state_q == S_DATA) ||
                     (state_q == S_CSUM);
    assign tmo     = (TIMEOUT_CYCLES != 0) && timed && !accept &&
                     (idle_q == IDLE_LIM);
    assign csum_ok = (in_data == csum_q);

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            idx_q       <= '0;
            idle_q      <= '0;
            csum_q      <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            write_q     <= 1'b0;
            frame_q     <= '0;
            err_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            csum_q      <= csum_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            write_q     <= write_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            en_q        <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HUNT: begin
                if (accept && in_data == SYNC_BYTE) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (accept)   state_d = S_DATA;
                else if (tmo) state_d = S_HUNT;
            end
            S_DATA: begin
                if (accept && idx_q == 2'd3) state_d = S_CSUM;
                else if (tmo)                state_d = S_HUNT;
            end
            S_CSUM: begin
                if (accept)   state_d = csum_ok ? S_WRITE : S_HUNT;
                else if (tmo) state_d = S_HUNT;
            end
            S_WRITE: begin
                if (!waitrequest) state_d = S_HUNT;
            end
            default: state_d = S_HUNT;
        endcase
    end

    // Datapath and counters
    always_comb begin
        idx_d       = idx_q;
        csum_d      = csum_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        frame_d     = frame_q;
        err_d       = err_q;
        write_d     = (state_d == S_WRITE);
        // Idle count restarts on any accepted byte, timeout or state exit.
        idle_d      = (timed && !accept && !tmo) ? idle_q + 1'b1 : '0;

        if (accept && state_q == S_ADDR) begin
            address_d = in_data;
            csum_d    = in_data;
            idx_d     = 2'd0;
        end
        if (accept && state_q == S_DATA) begin
            writedata_d[idx_q*8 +: 8] = in_data;
            csum_d = csum_q ^ in_data;
            idx_d  = idx_q + 2'd1;
        end
        if (state_q == S_WRITE && !waitrequest && frame_q != 16'hFFFF)
            frame_d = frame_q + 16'd1;
        // An accepted byte suppresses tmo, so at most one increment.
        if (((state_q == S_CSUM && accept && !csum_ok) || tmo) &&
            err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
    end

    // Output decode
    always_comb begin
        in_ready = en_q && (state_q != S_WRITE);
        busy     = (state_q != S_HUNT);
    end

    assign address   = address_q;
    assign writedata = writedata_q;
    assign write     = write_q;
    assign frame_cnt = frame_q;
    assign err_cnt   = err_q;

endmodule
